// File: rtl/debug_uart_tx.sv
// rtl/debug_uart_tx.sv - serialises a sequence-numbered debug vector snapshot as framed UART bytes.
// Optional trailing XOR checksum byte when DEBUG_UART_CHECKSUM_EN is defined.
module debug_uart_tx #(
  parameter int DEBUG_BYTES  = 32,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic [8:DEBUG_BYTES*8-1]  debug_vector,
  input  logic                      send,
  output logic                      busy,
  output logic                      done,
  output logic                      tx,
  output logic [7:0]                seq
);

`ifdef DEBUG_UART_CHECKSUM_EN
  localparam int NUM_BYTES = DEBUG_BYTES + 1;
`else
  localparam int NUM_BYTES = DEBUG_BYTES;
`endif
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int SNAP_W = (DEBUG_BYTES > 1) ? $clog2(DEBUG_BYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            r_state, w_state_nxt;
  logic [BAUD_W-1:0] r_baud, w_baud_nxt;
  logic [2:0]        r_bit, w_bit_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [7:0]        r_seq, w_seq_nxt;
  logic              r_tx, w_tx_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              w_capture;
  logic              w_baud_end;
  logic [7:0]        w_byte;
  logic [7:0]        r_snap [DEBUG_BYTES];

  assign w_baud_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

`ifdef DEBUG_UART_CHECKSUM_EN
  logic [7:0] r_csum, w_csum;

  always_comb begin
    w_csum = r_seq;
    for (int k = 1; k < DEBUG_BYTES; k++) w_csum = w_csum ^ debug_vector[8*k +: 8];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)        r_csum <= 8'h00;
    else if (w_capture) r_csum <= w_csum;
  end

  assign w_byte = (r_idx == IDX_W'(DEBUG_BYTES)) ? r_csum : r_snap[r_idx[SNAP_W-1:0]];
`else
  assign w_byte = r_snap[r_idx];
`endif

  // Byte 0 of the packet carries the frame sequence number instead of cpu data.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int k = 0; k < DEBUG_BYTES; k++) r_snap[k] <= 8'h00;
    end else if (w_capture) begin
      r_snap[0] <= r_seq;
      for (int k = 1; k < DEBUG_BYTES; k++) r_snap[k] <= debug_vector[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_idx   <= '0;
      r_seq   <= 8'h00;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_idx   <= w_idx_nxt;
      r_seq   <= w_seq_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // tx is computed one cycle ahead so the line level is a plain register output.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + BAUD_W'(1);
    w_bit_nxt   = r_bit;
    w_idx_nxt   = r_idx;
    w_seq_nxt   = r_seq;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (send) begin
          w_capture   = 1'b1;
          w_state_nxt = S_START;
          w_idx_nxt   = '0;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = 3'd0;
          w_state_nxt = S_DATA;
          w_tx_nxt    = w_byte[0];
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
            w_tx_nxt  = w_byte[r_bit + 3'd1];
          end
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_idx == IDX_W'(NUM_BYTES - 1)) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_seq_nxt   = r_seq + 8'd1;
            w_tx_nxt    = 1'b1;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;
  assign seq  = r_seq;

endmodule

// File: tb/tb_debug_uart_tx.sv
// tb/tb_debug_uart_tx.sv - randomized self-checking bench for debug_uart_tx against a bit-stream model.
module tb_debug_uart_tx;
  localparam int DB = 32;
  localparam int C  = 4;
`ifdef DEBUG_UART_CHECKSUM_EN
  localparam int NB = DB + 1;
`else
  localparam int NB = DB;
`endif
  localparam int L    = NB * 10 * C;
  localparam int MAXC = 4000;

  typedef logic [7:0] bq_t[$];

  logic            clk = 1'b0;
  logic            nreset;
  logic            send;
  logic [8:DB*8-1] dvec;
  logic            busy, done, tx;
  logic [7:0]      seq;
  logic [7:0]      dv [1:DB-1];

  logic       s_tx   [MAXC];
  logic       s_busy [MAXC];
  logic       s_done [MAXC];
  logic [7:0] s_seq  [MAXC];
  logic       rst_tx, rst_busy;
  logic [7:0] m_seq;
  int         n_tests = 0;
  int         n_fail  = 0;

  debug_uart_tx #(.DEBUG_BYTES(DB), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .nreset(nreset), .debug_vector(dvec), .send(send),
    .busy(busy), .done(done), .tx(tx), .seq(seq)
  );

  always #5 clk = ~clk;

  // Byte k occupies dvec[8k:8k+7] with the lowest index as MSB.
  always_comb begin
    dvec = '0;
    for (int k = 1; k < DB; k++)
      for (int i = 0; i < 8; i++) dvec[8*k + 7 - i] = dv[k][i];
  end

  function automatic bq_t make_pkt(input logic [7:0] s);
    bq_t q;
    q.push_back(s);
    for (int k = 1; k < DB; k++) q.push_back(dv[k]);
`ifdef DEBUG_UART_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      foreach (q[i]) x = x ^ q[i];
      q.push_back(x);
    end
`endif
    return q;
  endfunction

  // Line level m cycles after accept: 10 bit slots per byte, C cycles per slot.
  function automatic logic exp_tx(input bq_t pkt, input int m);
    int j, p;
    j = m / (10 * C);
    p = (m / C) % 10;
    if (j >= pkt.size()) return 1'b1;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return pkt[j][p-1];
  endfunction

  function automatic int wave_err(input bq_t pkt, input int off, input int len);
    int n = 0;
    for (int m = 0; m < len; m++) if (s_tx[off+m] !== exp_tx(pkt, m)) n++;
    return n;
  endfunction

  function automatic logic [7:0] decode(input int off, input int j);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = s_tx[off + (j*10 + 1 + i)*C + C/2];
    return b;
  endfunction

  function automatic int count_done(input int from, input int to);
    int n = 0;
    for (int k = from; k < to; k++) if (s_done[k] === 1'b1) n++;
    return n;
  endfunction

  function automatic int first_done(input int from, input int to);
    for (int k = from; k < to; k++) if (s_done[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int not_idle(input int from, input int to);
    int n = 0;
    for (int k = from; k < to; k++) if (s_tx[k] !== 1'b1 || s_busy[k] !== 1'b0) n++;
    return n;
  endfunction

  task automatic rand_dv();
    for (int k = 1; k < DB; k++) dv[k] = 8'($urandom_range(0, 255));
  endtask

  // Pulses send, then records outputs at each falling edge; sample k follows the k-th edge after accept.
  task automatic capture(input int ncyc, input bit chain, input int poke_at, input int rst_at);
    bit chained = 1'b0;
    @(negedge clk);
    send = 1'b1;
    @(posedge clk);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      send = 1'b0;
      s_tx[k] = tx; s_busy[k] = busy; s_done[k] = done; s_seq[k] = seq;
      if (chain && done === 1'b1 && !chained) begin
        send = 1'b1;
        chained = 1'b1;
      end
      if (k == poke_at) begin
        for (int j = 1; j < DB; j++) dv[j] = ~dv[j];
        send = 1'b1;
      end
      if (k == rst_at) begin
        nreset = 1'b0;
        #1;
        rst_tx = tx;
        rst_busy = busy;
      end
      if (k == rst_at + 3) nreset = 1'b1;
    end
    send = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    nreset = 1'b0;
    send = 1'b0;
    for (int k = 1; k < DB; k++) dv[k] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    n_tests++; if (tx !== 1'b1)    begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (seq !== 8'h00)  begin n_fail++; $display("FAIL reset_seq: got %h expected 00", seq); end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL reset_idle_tx: got %0d low cycles expected 0", bad); end
    m_seq = 8'h00;
  endtask

  task automatic test_single();
    bq_t pkt;
    int  run = 0;
    int  n   = L + 40;
    for (int k = 1; k < DB; k++) dv[k] = 8'h00;
    dv[1] = 8'h41;
    dv[31] = 8'hC3;
    pkt = make_pkt(m_seq);
    capture(n, 1'b0, -1, -1);
    n_tests++; if (s_busy[0] !== 1'b1) begin n_fail++; $display("FAIL single_busy_accept: got %b expected 1", s_busy[0]); end
    while (run < 2*C && s_tx[10*C + run] === 1'b0) run++;
    n_tests++; if (run !== C) begin n_fail++; $display("FAIL single_start_len: got %0d expected %0d", run, C); end
    n_tests++; if (wave_err(pkt, 0, L) !== 0)
      begin n_fail++; $display("FAIL single_wave: got %0d bad cycles expected 0", wave_err(pkt, 0, L)); end
    for (int j = 0; j < NB; j++) begin
      n_tests++; if (decode(0, j) !== pkt[j])
        begin n_fail++; $display("FAIL single_byte%0d: got %h expected %h", j, decode(0, j), pkt[j]); end
    end
    n_tests++; if (first_done(0, n) !== L) begin n_fail++; $display("FAIL single_done_at: got %0d expected %0d", first_done(0, n), L); end
    n_tests++; if (count_done(0, n) !== 1) begin n_fail++; $display("FAIL single_done_cnt: got %0d expected 1", count_done(0, n)); end
    n_tests++; if (s_busy[L-1] !== 1'b1 || s_busy[L] !== 1'b0)
      begin n_fail++; $display("FAIL single_busy_end: got %b%b expected 10", s_busy[L-1], s_busy[L]); end
    n_tests++; if (s_seq[L] !== m_seq + 8'd1) begin n_fail++; $display("FAIL single_seq: got %h expected %h", s_seq[L], m_seq + 8'd1); end
    n_tests++; if (not_idle(L, n) !== 0) begin n_fail++; $display("FAIL single_idle_after: got %0d expected 0", not_idle(L, n)); end
    m_seq = m_seq + 8'd1;
  endtask

  task automatic test_back_to_back();
    bq_t pa, pb;
    int  n = 2*L + 41;
    rand_dv();
    pa = make_pkt(m_seq);
    pb = make_pkt(m_seq + 8'd1);
    capture(n, 1'b1, -1, -1);
    n_tests++; if (wave_err(pa, 0, L) !== 0) begin n_fail++; $display("FAIL b2b_wave_a: got %0d expected 0", wave_err(pa, 0, L)); end
    n_tests++; if (s_done[L] !== 1'b1 || s_tx[L] !== 1'b1)
      begin n_fail++; $display("FAIL b2b_done_a: got done=%b tx=%b expected 1 1", s_done[L], s_tx[L]); end
    n_tests++; if (s_busy[L+1] !== 1'b1 || s_tx[L+1] !== 1'b0)
      begin n_fail++; $display("FAIL b2b_no_gap: got busy=%b tx=%b expected 1 0", s_busy[L+1], s_tx[L+1]); end
    n_tests++; if (wave_err(pb, L+1, L) !== 0) begin n_fail++; $display("FAIL b2b_wave_b: got %0d expected 0", wave_err(pb, L+1, L)); end
    n_tests++; if (decode(L+1, 0) !== m_seq + 8'd1)
      begin n_fail++; $display("FAIL b2b_byte0: got %h expected %h", decode(L+1, 0), m_seq + 8'd1); end
    n_tests++; if (first_done(L+1, n) !== 2*L + 1)
      begin n_fail++; $display("FAIL b2b_done_b: got %0d expected %0d", first_done(L+1, n), 2*L + 1); end
    n_tests++; if (count_done(0, n) !== 2) begin n_fail++; $display("FAIL b2b_done_cnt: got %0d expected 2", count_done(0, n)); end
    n_tests++; if (s_seq[2*L+1] !== m_seq + 8'd2)
      begin n_fail++; $display("FAIL b2b_seq: got %h expected %h", s_seq[2*L+1], m_seq + 8'd2); end
    m_seq = m_seq + 8'd2;
  endtask

  task automatic test_mid_packet();
    bq_t pkt;
    int  bad = 0;
    int  n   = L + 200;
    rand_dv();
    pkt = make_pkt(m_seq);
    capture(n, 1'b0, 300, -1);
    n_tests++; if (wave_err(pkt, 0, L) !== 0) begin n_fail++; $display("FAIL mid_wave: got %0d expected 0", wave_err(pkt, 0, L)); end
    for (int j = 0; j < NB; j++) if (decode(0, j) !== pkt[j]) bad++;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL mid_bytes: got %0d bad bytes expected 0", bad); end
    n_tests++; if (count_done(0, n) !== 1) begin n_fail++; $display("FAIL mid_done_cnt: got %0d expected 1", count_done(0, n)); end
    n_tests++; if (first_done(0, n) !== L) begin n_fail++; $display("FAIL mid_done_at: got %0d expected %0d", first_done(0, n), L); end
    n_tests++; if (not_idle(L, n) !== 0) begin n_fail++; $display("FAIL mid_no_extra: got %0d expected 0", not_idle(L, n)); end
    m_seq = m_seq + 8'd1;
  endtask

  task automatic test_reset_mid();
    bq_t pkt;
    int  ra = (3*10 + 1 + 5)*C + C/2;
    int  n  = ra + 100;
    rand_dv();
    pkt = make_pkt(m_seq);
    capture(n, 1'b0, -1, ra);
    n_tests++; if (wave_err(pkt, 0, ra + 1) !== 0) begin n_fail++; $display("FAIL rmid_wave: got %0d expected 0", wave_err(pkt, 0, ra + 1)); end
    n_tests++; if (rst_tx !== 1'b1 || rst_busy !== 1'b0)
      begin n_fail++; $display("FAIL rmid_immediate: got tx=%b busy=%b expected 1 0", rst_tx, rst_busy); end
    n_tests++; if (count_done(0, n) !== 0) begin n_fail++; $display("FAIL rmid_done: got %0d expected 0", count_done(0, n)); end
    n_tests++; if (not_idle(ra + 1, n) !== 0) begin n_fail++; $display("FAIL rmid_idle: got %0d expected 0", not_idle(ra + 1, n)); end
    n_tests++; if (s_seq[n-1] !== 8'h00) begin n_fail++; $display("FAIL rmid_seq: got %h expected 00", s_seq[n-1]); end
    m_seq = 8'h00;
    rand_dv();
    pkt = make_pkt(m_seq);
    capture(L + 10, 1'b0, -1, -1);
    n_tests++; if (decode(0, 0) !== 8'h00) begin n_fail++; $display("FAIL rmid_next_byte0: got %h expected 00", decode(0, 0)); end
    n_tests++; if (wave_err(pkt, 0, L) !== 0) begin n_fail++; $display("FAIL rmid_next_wave: got %0d expected 0", wave_err(pkt, 0, L)); end
    n_tests++; if (first_done(0, L + 10) !== L) begin n_fail++; $display("FAIL rmid_next_done: got %0d expected %0d", first_done(0, L + 10), L); end
    m_seq = m_seq + 8'd1;
  endtask

  task automatic test_random();
    bq_t pkt;
    for (int r = 0; r < 2; r++) begin
      rand_dv();
      pkt = make_pkt(m_seq);
      capture(L + 10, 1'b0, -1, -1);
      n_tests++; if (wave_err(pkt, 0, L) !== 0) begin n_fail++; $display("FAIL rand%0d_wave: got %0d expected 0", r, wave_err(pkt, 0, L)); end
      n_tests++; if (first_done(0, L + 10) !== L)
        begin n_fail++; $display("FAIL rand%0d_done: got %0d expected %0d", r, first_done(0, L + 10), L); end
      n_tests++; if (s_seq[L] !== m_seq + 8'd1)
        begin n_fail++; $display("FAIL rand%0d_seq: got %h expected %h", r, s_seq[L], m_seq + 8'd1); end
      m_seq = m_seq + 8'd1;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_mid_packet();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
